// File: rtl/cp0_exc_ctrl.sv
// ----------------------------------------------------------------------------
// cp0_exc_ctrl -- coprocessor-0 register file and exception controller for
// the multicycle MIPS-lite core.
//
// Holds SR (12), Cause (13), EPC (14) and PRId (15). It samples the hardware
// interrupt lines into Cause.IP and raises int_req when an enabled interrupt
// is pending. It also takes interrupt or synchronous-exception entry, which
// captures EPC, sets EXL and records ExcCode.
//
// Optional feature macro: CP0_TIMER_EN
//   Adds Count (sel 9) and Compare (sel 11) with a sticky timer pending bit
//   in Cause[15], which is masked by SR[15]. NUM_HWINT must be <= 5 when set.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   wen        mtc0 write strobe
//   sel        CP0 register number for read and write
//   din        mtc0 write data
//   dout       mfc0 read data, combinational on sel
//   hwint      level-sensitive hardware interrupt lines
//   pc         PC to resume; captured into EPC on entry
//   exc_req    synchronous exception request
//   exc_code   ExcCode for exc_req
//   eret       eret strobe, clears EXL
//   int_req    enabled interrupt pending (combinational)
//   exc_entry  one-cycle pulse in the cycle after entry is taken
//   epc_out    current EPC for the eret redirect
// ----------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h0000_ffff,
  parameter int          EXCCODE_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen,
  input  logic [4:0]           sel,
  input  logic [31:0]          din,
  output logic [31:0]          dout,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic [31:0]          pc,
  input  logic                 exc_req,
  input  logic [EXCCODE_W-1:0] exc_code,
  input  logic                 eret,
  output logic                 int_req,
  output logic                 exc_entry,
  output logic [31:0]          epc_out
);

  localparam logic [4:0] SEL_COUNT   = 5'd9;
  localparam logic [4:0] SEL_COMPARE = 5'd11;
  localparam logic [4:0] SEL_SR      = 5'd12;
  localparam logic [4:0] SEL_CAUSE   = 5'd13;
  localparam logic [4:0] SEL_EPC     = 5'd14;
  localparam logic [4:0] SEL_PRID    = 5'd15;

  // One-hot so that exc_entry comes straight from a flop bit.
  localparam logic [2:0] ST_RUN     = 3'b001;
  localparam logic [2:0] ST_ENTRY   = 3'b010;
  localparam logic [2:0] ST_HANDLER = 3'b100;

  logic [2:0]           state_r;
  logic [2:0]           state_nxt_s;
  logic [NUM_HWINT-1:0] im_r;
  logic [NUM_HWINT-1:0] ip_r;
  logic                 ie_r;
  logic                 exl_r;
  logic [EXCCODE_W-1:0] code_r;
  logic [31:0]          epc_r;
  logic                 pend_s;
  logic                 int_req_s;
  logic                 entry_take_s;
  logic                 exc_entry_s;
  logic [31:0]          sr_s;
  logic [31:0]          cause_s;
  logic [31:0]          dout_s;
  logic                 sr_wr_s;

  assign sr_wr_s = wen && (sel == SEL_SR);

`ifdef CP0_TIMER_EN
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        tip_r;
  logic        im_t_r;

  // Free-running Count; an mtc0 value becomes the base for the next increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_r <= 32'd0;
    else if (wen && (sel == SEL_COUNT)) count_r <= din;
    else count_r <= count_r + 32'd1;
  end

  // Compare register and sticky timer pending bit (only a Compare write clears it).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      compare_r <= 32'd0;
      tip_r     <= 1'b0;
    end else if (wen && (sel == SEL_COMPARE)) begin
      compare_r <= din;
      tip_r     <= 1'b0;
    end else if (count_r == compare_r) begin
      tip_r     <= 1'b1;
    end
  end

  // Timer interrupt mask, SR bit 15.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) im_t_r <= 1'b0;
    else if (sr_wr_s) im_t_r <= din[15];
  end

  assign pend_s = (|(ip_r & im_r)) | (tip_r & im_t_r);
`else
  assign pend_s = |(ip_r & im_r);
`endif

  assign int_req_s    = pend_s & ie_r & ~exl_r;
  assign entry_take_s = (state_r == ST_RUN) && !exl_r && (exc_req || int_req_s);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_RUN;
    else      state_r <= state_nxt_s;
  end

  // FSM next-state logic; eret outside HANDLER only clears EXL.
  always_comb begin
    state_nxt_s = ST_RUN;
    case (state_r)
      ST_RUN:     state_nxt_s = entry_take_s ? ST_ENTRY : ST_RUN;
      ST_ENTRY:   state_nxt_s = ST_HANDLER;
      ST_HANDLER: state_nxt_s = eret ? ST_RUN : ST_HANDLER;
      default:    state_nxt_s = ST_RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    exc_entry_s = 1'b0;
    case (state_r)
      ST_ENTRY: exc_entry_s = 1'b1;
      default:  exc_entry_s = 1'b0;
    endcase
  end

  // Cause.IP tracks hwint through a single register stage (not sticky).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ip_r <= '0;
    else      ip_r <= hwint;
  end

  // SR.IM / SR.IE follow mtc0 even on an entry or eret edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_r <= '0;
      ie_r <= 1'b0;
    end else if (sr_wr_s) begin
      im_r <= din[10 +: NUM_HWINT];
      ie_r <= din[0];
    end
  end

  // EXL: entry beats eret, and both beat an mtc0 to SR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              exl_r <= 1'b0;
    else if (entry_take_s) exl_r <= 1'b1;
    else if (eret)         exl_r <= 1'b0;
    else if (sr_wr_s)      exl_r <= din[1];
  end

  // EPC: the entry capture wins over a simultaneous mtc0; both are word-aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               epc_r <= 32'd0;
    else if (entry_take_s)                  epc_r <= pc & 32'hffff_fffc;
    else if (wen && (sel == SEL_EPC))       epc_r <= din & 32'hffff_fffc;
  end

  // ExcCode is recorded on entry; interrupts record 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              code_r <= '0;
    else if (entry_take_s) code_r <= exc_req ? exc_code : {EXCCODE_W{1'b0}};
  end

  // Assemble the architectural SR and Cause words.
  always_comb begin
    sr_s    = 32'd0;
    cause_s = 32'd0;
    sr_s[10 +: NUM_HWINT]    = im_r;
    sr_s[1]                  = exl_r;
    sr_s[0]                  = ie_r;
    cause_s[10 +: NUM_HWINT] = ip_r;
    cause_s[2 +: EXCCODE_W]  = code_r;
`ifdef CP0_TIMER_EN
    sr_s[15]    = im_t_r;
    cause_s[15] = tip_r;
`endif
  end

  // mfc0 read mux; unmapped numbers read 0.
  always_comb begin
    dout_s = 32'd0;
    case (sel)
`ifdef CP0_TIMER_EN
      SEL_COUNT:   dout_s = count_r;
      SEL_COMPARE: dout_s = compare_r;
`endif
      SEL_SR:      dout_s = sr_s;
      SEL_CAUSE:   dout_s = cause_s;
      SEL_EPC:     dout_s = epc_r;
      SEL_PRID:    dout_s = PRID_VAL;
      default:     dout_s = 32'd0;
    endcase
  end

  assign dout      = dout_s;
  assign int_req   = int_req_s;
  assign exc_entry = exc_entry_s;
  assign epc_out   = epc_r;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
`timescale 1ns/1ps
module tb_cp0_exc_ctrl;

`ifdef CP0_TIMER_EN
  localparam int NH = 5;
  localparam logic [31:0] SR_MASK = (((32'd1 << NH) - 32'd1) << 10) | 32'h0000_8003;
`else
  localparam int NH = 6;
  localparam logic [31:0] SR_MASK = (((32'd1 << NH) - 32'd1) << 10) | 32'h0000_0003;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen = 1'b0;
  logic [4:0]    sel = 5'd0;
  logic [31:0]   din = 32'd0;
  logic [31:0]   dout;
  logic [NH-1:0] hwint = '0;
  logic [31:0]   pc = 32'd0;
  logic          exc_req = 1'b0;
  logic [4:0]    exc_code = 5'd0;
  logic          eret = 1'b0;
  logic          int_req;
  logic          exc_entry;
  logic [31:0]   epc_out;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_exc_ctrl #(.NUM_HWINT(NH), .PRID_VAL(32'h0000_ffff), .EXCCODE_W(5)) dut (
    .clk(clk), .rst(rst), .wen(wen), .sel(sel), .din(din), .dout(dout),
    .hwint(hwint), .pc(pc), .exc_req(exc_req), .exc_code(exc_code),
    .eret(eret), .int_req(int_req), .exc_entry(exc_entry), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  // Reference model: architectural words kept as plain 32-bit values.
  logic [31:0] m_sr = 32'd0;     // IM | EXL | IE as the software sees SR
  logic [31:0] m_ip = 32'd0;     // hardware IP bits, already at their Cause position
  logic [4:0]  m_code = 5'd0;
  logic [31:0] m_epc = 32'd0;
  int          m_phase = 0;      // 0 running, 1 entry cycle, 2 in handler
  logic [31:0] m_count = 32'd0;
  logic [31:0] m_cmpr = 32'd0;
  logic        m_tip = 1'b0;

  function automatic logic [31:0] m_cause();
    logic [31:0] c;
    c = m_ip | ({27'd0, m_code} << 2);
`ifdef CP0_TIMER_EN
    if (m_tip) c = c | 32'h0000_8000;
`endif
    return c;
  endfunction

  function automatic logic m_int();
    logic [31:0] pend;
    pend = m_cause() & m_sr & 32'h0000_fc00;
    return (pend != 32'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
`ifdef CP0_TIMER_EN
      5'd9:    return m_count;
      5'd11:   return m_cmpr;
`endif
      5'd12:   return m_sr;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_ffff;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_take();
    return (m_phase == 0) && !m_sr[1] && (exc_req || m_int());
  endfunction

  // Model update on each clock edge, from the pre-edge inputs.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_sr <= 32'd0; m_ip <= 32'd0; m_code <= 5'd0; m_epc <= 32'd0; m_phase <= 0;
      m_count <= 32'd0; m_cmpr <= 32'd0; m_tip <= 1'b0;
    end else begin
      logic [31:0] nsr;
      nsr = m_sr;
      if (wen && sel == 5'd12) nsr = din & SR_MASK;
      else nsr = m_sr;
      if (m_take()) nsr[1] = 1'b1;
      else if (eret) nsr[1] = 1'b0;
      m_sr <= nsr;
      m_ip <= {16'd0, 32'(hwint) << 10} & 32'h0000_ffff;
      if (m_take()) begin
        m_epc  <= {pc[31:2], 2'b00};
        m_code <= exc_req ? exc_code : 5'd0;
        m_phase <= 1;
      end else begin
        if (wen && sel == 5'd14) m_epc <= {din[31:2], 2'b00};
        if (m_phase == 1) m_phase <= 2;
        else if (m_phase == 2 && eret) m_phase <= 0;
      end
      m_count <= (wen && sel == 5'd9) ? din : m_count + 32'd1;
      if (wen && sel == 5'd11) begin
        m_cmpr <= din;
        m_tip  <= 1'b0;
      end else if (m_count == m_cmpr) begin
        m_tip <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    chk("dout", dout, m_read(sel));
    chk("int_req", {31'd0, int_req}, {31'd0, m_int()});
    chk("exc_entry", {31'd0, exc_entry}, {31'd0, (m_phase == 1)});
    chk("epc_out", epc_out, m_epc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] s, input logic [31:0] d);
    wen = 1'b1; sel = s; din = d;
    tick();
    wen = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [4:0] s, input logic [31:0] exp);
    sel = s;
    #1;
    chk(nm, dout, exp);
  endtask

  initial begin
    #2 rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset mid-cycle with live SR/EPC contents.
    wr(5'd12, 32'h0000_fc01);
    wr(5'd14, 32'h0000_0100);
    rd("sr_pre_reset", 5'd12, 32'h0000_fc01);
    rst = 1'b0;
    rd("sr_reset", 5'd12, 32'd0);
    rd("cause_reset", 5'd13, 32'd0);
    rd("epc_reset", 5'd14, 32'd0);
    chk("int_req_reset", {31'd0, int_req}, 32'd0);
    tick();
    rd("prid", 5'd15, 32'h0000_ffff);
    rst = 1'b1;
    tick();

    // Interrupt entry.
    wr(5'd12, 32'h0000_0401);
    pc = 32'h0000_3010; hwint = 1;
    tick();
    #1 chk("int_req_lat", {31'd0, int_req}, 32'd1);
    tick();
    chk("epc_int", epc_out, 32'h0000_3010);
    rd("sr_int", 5'd12, 32'h0000_0403);
    rd("cause_int", 5'd13, 32'h0000_0400);
    chk("entry_pulse", {31'd0, exc_entry}, 32'd1);
    chk("int_req_drop", {31'd0, int_req}, 32'd0);
    tick();
    chk("entry_end", {31'd0, exc_entry}, 32'd0);
    hwint = 0; eret = 1'b1;
    tick();
    eret = 1'b0;
    rd("sr_eret", 5'd12, 32'h0000_0401);

    // Exception beats interrupt; no nesting; int_req returns after eret.
    hwint = 1;
    tick();
    exc_req = 1'b1; exc_code = 5'd12; pc = 32'h0000_3200;
    tick();
    rd("cause_exc", 5'd13, 32'h0000_0430);
    exc_code = 5'd3;
    tick(); tick();
    exc_req = 1'b0;
    rd("cause_nonest", 5'd13, 32'h0000_0430);
    chk("epc_nonest", epc_out, 32'h0000_3200);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    #1 chk("int_req_reassert", {31'd0, int_req}, 32'd1);
    // Entry taken on the same edge as an SR write: IE from din, EXL forced to 1.
    wr(5'd12, 32'h0000_0400);
    rd("sr_entry_wr", 5'd12, 32'h0000_0402);
    rd("cause_entry_wr", 5'd13, 32'h0000_0400);
    hwint = 0;
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // EPC alignment and entry/mtc0 collision.
    wr(5'd14, 32'h0000_3007);
    rd("epc_align", 5'd14, 32'h0000_3004);
    wr(5'd12, 32'h0000_0401);
    hwint = 1;
    tick();
    pc = 32'h0000_3100;
    wr(5'd14, 32'h0000_5555);
    chk("epc_collide", epc_out, 32'h0000_3100);
    hwint = 0;
    tick();
    // eret and SR write together: EXL stays 0.
    eret = 1'b1;
    wr(5'd12, 32'h0000_0403);
    eret = 1'b0;
    rd("sr_eret_wr", 5'd12, 32'h0000_0401);

    // Masking and read-only registers.
    wr(5'd12, 32'h0000_0400);
    hwint = 1;
    tick(); tick();
    chk("mask_ie", {31'd0, int_req}, 32'd0);
    wr(5'd12, 32'h0000_0801);
    tick();
    chk("mask_im", {31'd0, int_req}, 32'd0);
    wr(5'd13, 32'hffff_ffff);
    rd("cause_ro", 5'd13, 32'h0000_0400);
    wr(5'd15, 32'h1234_5678);
    rd("prid_ro", 5'd15, 32'h0000_ffff);
    wr(5'd3, 32'hffff_ffff);
    rd("unmapped", 5'd3, 32'd0);
    hwint = 0;
    tick();

`ifdef CP0_TIMER_EN
    wr(5'd11, 32'd10);
    wr(5'd9, 32'd0);
    wr(5'd12, 32'h0000_8001);
    repeat (11) tick();
    sel = 5'd13;
    #1 chk("timer_pend", {31'd0, dout[15]}, 32'd1);
    chk("timer_entry", {31'd0, exc_entry}, 32'd1);
    wr(5'd11, 32'd20);
    sel = 5'd13;
    #1 chk("timer_clear", {31'd0, dout[15]}, 32'd0);
`else
    wr(5'd9, 32'h0000_00ff);
    rd("count_absent", 5'd9, 32'd0);
    wr(5'd11, 32'h0000_00ff);
    rd("compare_absent", 5'd11, 32'd0);
`endif

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
